// File: rtl/param_universal_shift_register.sv
// param_universal_shift_register: command-driven universal shift register with multi-step bursts
module param_universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_msb,
    input  logic             ser_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_ROR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ASR   = 3'b101;
    localparam logic [2:0] M_LOAD  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [2:0]       mode_r;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] step_q;
    logic             single;

    assign busy      = (state == RUN);
    assign cmd_ready = en && !busy;
    assign sout_msb  = q[WIDTH-1];
    assign sout_lsb  = q[0];
    assign single    = (mode == M_HOLD) || (mode == M_LOAD) || (mode == M_CLEAR);

    // serial fills are taken live on every step, not at acceptance
    always_comb begin
        step_q = q;
        case (mode_r)
            M_SHR:   step_q = {ser_msb, q[WIDTH-1:1]};
            M_SHL:   step_q = {q[WIDTH-2:0], ser_lsb};
            M_ROR:   step_q = {q[0], q[WIDTH-1:1]};
            M_ROL:   step_q = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ASR:   step_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default: step_q = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= '0;
            done      <= 1'b0;
            remaining <= '0;
            mode_r    <= M_HOLD;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: if (cmd_valid) begin
                        if (single) begin
                            q    <= (mode == M_LOAD) ? d : (mode == M_CLEAR) ? '0 : q;
                            done <= 1'b1;
                        end else if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            mode_r    <= mode;
                            remaining <= count;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        q         <= step_q;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_param_universal_shift_register.sv
// tb_param_universal_shift_register: directed self-checking bench for the universal shift register
module tb_param_universal_shift_register;
    logic       clk = 1'b0;
    logic       rst_n, en, cmd_valid, ser_msb, ser_lsb;
    logic [2:0] mode;
    logic [3:0] count;
    logic [7:0] d, q;
    logic       cmd_ready, sout_msb, sout_lsb, busy, done;
    int         checks = 0;
    int         failures = 0;

    param_universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .mode(mode), .count(count), .ser_msb(ser_msb), .ser_lsb(ser_lsb), .d(d),
        .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] m, input logic [3:0] c, input logic [7:0] dv);
        mode = m; count = c; d = dv; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cmd_valid = 1'b1;
        mode = 3'($urandom); count = 4'($urandom); d = 8'($urandom);
        ser_msb = 1'($urandom); ser_lsb = 1'($urandom);
        tick();
        mode = 3'($urandom); count = 4'($urandom); d = 8'($urandom);
        tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1; cmd_valid = 1'b0; ser_msb = 1'b0; ser_lsb = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'h1);

        issue(3'b110, 4'd0, 8'hA5);
        chk("load_q", 32'(q), 32'hA5);
        chk("load_done", 32'(done), 32'h1);
        chk("load_busy", 32'(busy), 32'h0);
        tick();
        chk("load_done_pulse", 32'(done), 32'h0);

        issue(3'b011, 4'd3, 8'h00);
        chk("ror_busy0", 32'(busy), 32'h1);
        chk("ror_q0", 32'(q), 32'hA5);
        mode = 3'b110; d = 8'hFF; cmd_valid = 1'b1;
        #1;
        chk("ror_ready_busy", 32'(cmd_ready), 32'h0);
        tick();
        chk("ror_q1", 32'(q), 32'hD2);
        chk("ror_busy1", 32'(busy), 32'h1);
        chk("ror_done1", 32'(done), 32'h0);
        tick();
        chk("ror_q2", 32'(q), 32'h69);
        cmd_valid = 1'b0;
        tick();
        chk("ror_q3", 32'(q), 32'hB4);
        chk("ror_busy3", 32'(busy), 32'h0);
        chk("ror_done3", 32'(done), 32'h1);
        chk("ror_sout_msb", 32'(sout_msb), 32'h1);
        chk("ror_sout_lsb", 32'(sout_lsb), 32'h0);
        tick();
        chk("ror_done_pulse", 32'(done), 32'h0);
        chk("ror_load_ignored", 32'(q), 32'hB4);

        issue(3'b110, 4'd0, 8'h90);
        chk("asr_pre", 32'(q), 32'h90);
        issue(3'b101, 4'd2, 8'h00);
        tick();
        chk("asr_q1", 32'(q), 32'hC8);
        chk("asr_done1", 32'(done), 32'h0);
        tick();
        chk("asr_q2", 32'(q), 32'hE4);
        chk("asr_done2", 32'(done), 32'h1);
        tick();
        chk("asr_done_pulse", 32'(done), 32'h0);

        d = 8'hFF;
        issue(3'b111, 4'd0, 8'hFF);
        chk("clear_q", 32'(q), 32'h0);
        chk("clear_done", 32'(done), 32'h1);
        ser_lsb = 1'b1;
        issue(3'b010, 4'd4, 8'h00);
        tick();
        chk("shl_q1", 32'(q), 32'h01);
        tick();
        chk("shl_q2", 32'(q), 32'h03);
        en = 1'b0;
        #1;
        chk("shl_ready_en0", 32'(cmd_ready), 32'h0);
        tick();
        chk("shl_stall_q1", 32'(q), 32'h03);
        chk("shl_stall_busy1", 32'(busy), 32'h1);
        tick();
        chk("shl_stall_q2", 32'(q), 32'h03);
        chk("shl_stall_done2", 32'(done), 32'h0);
        en = 1'b1;
        tick();
        chk("shl_q3", 32'(q), 32'h07);
        chk("shl_busy5", 32'(busy), 32'h1);
        tick();
        chk("shl_q4", 32'(q), 32'h0F);
        chk("shl_busy6", 32'(busy), 32'h0);
        chk("shl_done6", 32'(done), 32'h1);
        ser_lsb = 1'b0;

        ser_msb = 1'b1;
        issue(3'b001, 4'd0, 8'h00);
        chk("shr0_q", 32'(q), 32'h0F);
        chk("shr0_done", 32'(done), 32'h1);
        chk("shr0_busy", 32'(busy), 32'h0);
        tick();
        chk("shr0_done_pulse", 32'(done), 32'h0);
        chk("shr0_q_after", 32'(q), 32'h0F);
        ser_msb = 1'b0;

        issue(3'b110, 4'd0, 8'h3C);
        issue(3'b100, 4'd8, 8'h00);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rol8_busy", 32'(busy), 32'h1);
        end
        tick();
        chk("rol8_q", 32'(q), 32'h3C);
        chk("rol8_done", 32'(done), 32'h1);
        chk("rol8_busy_end", 32'(busy), 32'h0);

        issue(3'b100, 4'd5, 8'h00);
        tick();
        chk("rolrst_q1", 32'(q), 32'h78);
        tick();
        chk("rolrst_q2", 32'(q), 32'hF0);
        rst_n = 1'b0;
        tick();
        chk("rolrst_q", 32'(q), 32'h0);
        chk("rolrst_busy", 32'(busy), 32'h0);
        chk("rolrst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rolrst_no_done", 32'(done), 32'h0);
            chk("rolrst_q_hold", 32'(q), 32'h0);
        end
        chk("rolrst_ready", 32'(cmd_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
